// File: rtl/game_pkg.sv
// game_pkg
//   Shared definitions for the game and its text-mode display streamer:
//   default screen geometry, the glyph bytes for lit/dark pixels, the
//   terminal control bytes (cursor-home escape, CR, LF) and the streamer
//   state encoding.
//   No ports; constants, one typedef and one helper function only.
package game_pkg;

  // Default screen geometry and pixel glyphs
  localparam int         SCREEN_WIDTH_DEF  = 80;
  localparam int         SCREEN_HEIGHT_DEF = 24;
  localparam logic [7:0] ON_CHAR_DEF       = 8'h2A;  // '*'
  localparam logic [7:0] OFF_CHAR_DEF      = 8'h20;  // ' '

  // Terminal control bytes: ESC [ H moves the cursor to the top-left corner
  localparam logic [7:0] ESC_CHAR  = 8'h1B;
  localparam logic [7:0] CSI_CHAR  = 8'h5B;
  localparam logic [7:0] HOME_CHAR = 8'h48;
  localparam logic [7:0] CR_CHAR   = 8'h0D;
  localparam logic [7:0] LF_CHAR   = 8'h0A;
  localparam int         HOME_LEN  = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HOME  = 3'd1,
    ST_PIXEL = 3'd2,
    ST_CR    = 3'd3,
    ST_LF    = 3'd4
  } stream_state_t;

  // Byte of the cursor-home sequence selected by its index
  function automatic logic [7:0] home_byte(input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = ESC_CHAR;
      2'd1:    b = CSI_CHAR;
      default: b = HOME_CHAR;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/display_streamer.sv
// display_streamer
//   Serialises a 1-bit-per-pixel frame bitmap into a byte stream for a
//   text terminal: cursor-home escape, then each row as ON/OFF glyphs
//   followed by CR LF. The bitmap is captured when the frame starts, so the
//   producer may keep updating it while the frame drains.
//   Ports:
//     clk, rst    - rising-edge clock, asynchronous active-high reset
//     display     - frame bitmap, pixel (row r, col c) at bit r*SCREEN_WIDTH+c
//     start       - request one frame (ignored while busy)
//     char_data   - current stream byte (valid/ready handshake)
//     char_valid  - char_data holds a byte
//     char_ready  - sink accepts the byte this cycle
//     busy        - a frame is in progress
//     frame_done  - one-cycle pulse on return to idle after the last LF
module display_streamer
  import game_pkg::*;
#(
  parameter int         SCREEN_WIDTH  = SCREEN_WIDTH_DEF,
  parameter int         SCREEN_HEIGHT = SCREEN_HEIGHT_DEF,
  parameter logic [7:0] ON_CHAR       = ON_CHAR_DEF,
  parameter logic [7:0] OFF_CHAR      = OFF_CHAR_DEF
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [SCREEN_WIDTH*SCREEN_HEIGHT-1:0] display,
  input  logic                                  start,
  output logic [7:0]                            char_data,
  output logic                                  char_valid,
  input  logic                                  char_ready,
  output logic                                  busy,
  output logic                                  frame_done
);

  localparam int NPIX  = SCREEN_WIDTH * SCREEN_HEIGHT;
  localparam int COL_W = (SCREEN_WIDTH  > 1) ? $clog2(SCREEN_WIDTH)  : 1;
  localparam int ROW_W = (SCREEN_HEIGHT > 1) ? $clog2(SCREEN_HEIGHT) : 1;
  localparam int IDX_W = (NPIX > 1) ? $clog2(NPIX) : 1;

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(SCREEN_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(SCREEN_HEIGHT - 1);
  localparam logic [1:0]       HOME_LAST = 2'(HOME_LEN - 1);

  stream_state_t     state;
  logic [NPIX-1:0]   snapshot;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [1:0]        home_idx;
  logic [IDX_W-1:0]  pix_idx;
  logic              xfer;

  assign xfer    = char_valid & char_ready;
  assign pix_idx = IDX_W'(row) * IDX_W'(SCREEN_WIDTH) + IDX_W'(col);

  // Sequencer. char_valid and busy are registered alongside the state so
  // they are both 1 exactly while the state is not IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      snapshot   <= '0;
      col        <= '0;
      row        <= '0;
      home_idx   <= '0;
      char_valid <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            snapshot   <= display;
            col        <= '0;
            row        <= '0;
            home_idx   <= '0;
            state      <= ST_HOME;
            char_valid <= 1'b1;
            busy       <= 1'b1;
          end
        end
        ST_HOME: begin
          if (xfer) begin
            if (home_idx == HOME_LAST) begin
              home_idx <= '0;
              state    <= ST_PIXEL;
            end else begin
              home_idx <= home_idx + 2'd1;
            end
          end
        end
        ST_PIXEL: begin
          if (xfer) begin
            if (col == COL_LAST) begin
              col   <= '0;
              state <= ST_CR;
            end else begin
              col <= col + COL_W'(1);
            end
          end
        end
        ST_CR: begin
          if (xfer) state <= ST_LF;
        end
        ST_LF: begin
          if (xfer) begin
            if (row == ROW_LAST) begin
              // Last line feed: close the frame
              row        <= '0;
              state      <= ST_IDLE;
              char_valid <= 1'b0;
              busy       <= 1'b0;
              frame_done <= 1'b1;
            end else begin
              row   <= row + ROW_W'(1);
              state <= ST_PIXEL;
            end
          end
        end
        default: begin
          state      <= ST_IDLE;
          char_valid <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

  // Byte mux: a pure function of the registered state, so the byte is
  // automatically held while the sink stalls.
  always_comb begin
    char_data = 8'h00;
    unique case (state)
      ST_HOME:  char_data = home_byte(home_idx);
      ST_PIXEL: char_data = snapshot[pix_idx] ? ON_CHAR : OFF_CHAR;
      ST_CR:    char_data = CR_CHAR;
      ST_LF:    char_data = LF_CHAR;
      default:  char_data = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_display_streamer.sv
// tb_display_streamer
//   Self-checking bench for display_streamer at default geometry (80x24).
//   Expected byte streams are built from the frame layout rules directly
//   from the bitmap; the sink randomly applies backpressure in some tests.
module tb_display_streamer;

  localparam int W      = 80;
  localparam int H      = 24;
  localparam int N      = W * H;
  localparam int FRAME  = 3 + H * (W + 2);

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  display;
  logic          start;
  logic [7:0]    char_data;
  logic          char_valid;
  logic          char_ready;
  logic          busy;
  logic          frame_done;

  display_streamer dut (
    .clk        (clk),
    .rst        (rst),
    .display    (display),
    .start      (start),
    .char_data  (char_data),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int stall_bad, valid_drop, done_ok, timed_out, ncyc;

  // Reference stream: home escape, then per row W glyphs plus CR LF
  task automatic build_expected(input logic [N-1:0] bm);
    exp_q.delete();
    exp_q.push_back(8'h1B);
    exp_q.push_back(8'h5B);
    exp_q.push_back(8'h48);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++)
        exp_q.push_back(bm[r*W+c] ? 8'h2A : 8'h20);
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endtask

  // Index of first difference between captured and expected streams, -1 if equal
  function automatic int first_diff();
    int n;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      if (got_q[i] !== exp_q[i]) return i;
    if (got_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  function automatic logic [N-1:0] rand_bitmap();
    logic [N-1:0] bm;
    for (int i = 0; i < N / 32; i++) bm[i*32 +: 32] = $urandom;
    return bm;
  endfunction

  // Called at posedge+1 while idle; returns at posedge+1 with the frame started
  task automatic launch(input logic [N-1:0] bm);
    display = bm;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
  endtask

  // Sink: collects transferred bytes until frame_done, stop_at bytes, or budget.
  // mode 0: ready=1; mode 1: random ready (forced every 3rd cycle);
  // mode 2: ready=1, bitmap overwritten at cycle 5, extra start at cycle 300.
  task automatic capture(input int mode, input int stop_at, input int budget,
                         input bit chain, input logic [N-1:0] next_bm);
    bit         prev_stall;
    logic [7:0] prev_data;
    int         last_xfer;
    bit         at_neg;
    got_q.delete();
    stall_bad = 0; valid_drop = 0; done_ok = 0; timed_out = 1; ncyc = -1;
    last_xfer = -10; prev_stall = 0; prev_data = 8'h00; at_neg = 0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      case (mode)
        1:       char_ready = (cyc % 3 == 2) ? 1'b1 : 1'($urandom_range(0, 1));
        2: begin
          char_ready = 1'b1;
          if (cyc == 5) display = '1;
          start = (cyc == 300);
        end
        default: char_ready = 1'b1;
      endcase
      @(negedge clk);
      if (frame_done) begin
        if (last_xfer == cyc - 1 && !char_valid && !busy) done_ok = 1;
        timed_out = 0;
        ncyc = cyc;
        if (chain) begin
          display = next_bm;
          start   = 1'b1;
        end
        at_neg = 1;
        break;
      end
      if (prev_stall && char_data !== prev_data) stall_bad++;
      if (!char_valid || !busy) valid_drop++;
      if (char_valid && char_ready) begin
        got_q.push_back(char_data);
        last_xfer = cyc;
      end
      prev_stall = char_valid && !char_ready;
      prev_data  = char_data;
      if (stop_at > 0 && got_q.size() == stop_at) begin
        timed_out = 0;
        at_neg = 1;
        break;
      end
      @(posedge clk); #1;
    end
    if (at_neg) begin
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  // Standard end-of-frame comparisons shared by the full-frame scenarios
  // are written out in each task so each scenario reports its own names.

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; char_ready = 1'b1; display = '1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({char_valid, busy, frame_done} !== 3'b000 || char_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_outputs: valid=%b busy=%b done=%b data=%h, required 0 0 0 00",
               char_valid, busy, frame_done, char_data);
    end
    start = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (char_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: valid=%b busy=%b, required 0 0", char_valid, busy);
    end
    $display("test_reset done");
  endtask

  task automatic test_frame(input string name, input logic [N-1:0] bm, input int mode);
    int d;
    build_expected(bm);
    launch(bm);
    capture(mode, 0, 3 * FRAME + 20, 1'b0, '0);
    d = first_diff();
    checks++;
    if (timed_out != 0) begin
      failures++; $display("FAIL %s_timeout: frame_done not seen, bytes=%0d", name, got_q.size());
    end
    checks++;
    if (got_q.size() != FRAME) begin
      failures++; $display("FAIL %s_count: got %0d bytes, required %0d", name, got_q.size(), FRAME);
    end
    checks++;
    if (d >= 0) begin
      failures++;
      $display("FAIL %s_bytes: first difference at %0d got %h required %h", name, d,
               (d < got_q.size()) ? got_q[d] : 8'hxx, (d < exp_q.size()) ? exp_q[d] : 8'hxx);
    end
    checks++;
    if (done_ok != 1) begin
      failures++; $display("FAIL %s_done: frame_done timing/idle wrong, got %0d required 1", name, done_ok);
    end
    checks++;
    if (valid_drop != 0 || stall_bad != 0) begin
      failures++;
      $display("FAIL %s_handshake: valid drops %0d, stall changes %0d, required 0 0", name, valid_drop, stall_bad);
    end
    if (mode == 0) begin
      checks++;
      if (ncyc != FRAME) begin
        failures++; $display("FAIL %s_throughput: %0d cycles, required %0d", name, ncyc, FRAME);
      end
    end
    checks++;
    if (frame_done !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL %s_after: done=%b busy=%b, required 0 0", name, frame_done, busy);
    end
    $display("%s: %0d bytes in %0d cycles", name, got_q.size(), ncyc);
  endtask

  task automatic test_sparse();
    logic [N-1:0] bm;
    bm = '0;
    bm[0] = 1'b1; bm[12*W+40] = 1'b1; bm[N-1] = 1'b1;
    test_frame("sparse", bm, 0);
    checks++;
    if (got_q.size() != FRAME || got_q[3] !== 8'h2A || got_q[1027] !== 8'h2A || got_q[1968] !== 8'h2A) begin
      failures++;
      $display("FAIL sparse_marks: lit bytes at 3/1027/1968 missing, size %0d required %0d", got_q.size(), FRAME);
    end
  endtask

  task automatic test_snapshot();
    logic [N-1:0] bm;
    int d;
    bit idle_ok;
    bm = rand_bitmap();
    build_expected(bm);
    launch(bm);
    capture(2, 0, FRAME + 20, 1'b0, '0);
    d = first_diff();
    checks++;
    if (timed_out != 0 || d >= 0) begin
      failures++;
      $display("FAIL snapshot_bytes: timeout=%0d first difference %0d, required 0 and -1", timed_out, d);
    end
    idle_ok = 1;
    for (int i = 0; i < 5; i++) begin
      if (busy !== 1'b0 || char_valid !== 1'b0) idle_ok = 0;
      @(posedge clk); #1;
    end
    checks++;
    if (!idle_ok) begin
      failures++; $display("FAIL snapshot_no_queue: streamer restarted, got busy after frame, required idle");
    end
    $display("snapshot: %0d bytes", got_q.size());
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] bm;
    int d;
    bit quiet;
    bm = rand_bitmap();
    build_expected(bm);
    launch(bm);
    capture(0, 500, FRAME, 1'b0, '0);
    checks++;
    if (got_q.size() != 500 || first_diff() != 500) begin
      failures++; $display("FAIL rstmid_prefix: %0d bytes, first difference %0d, required 500 500", got_q.size(), first_diff());
    end
    rst = 1'b1;
    #1;
    checks++;
    if (char_valid !== 1'b0 || busy !== 1'b0 || char_data !== 8'h00) begin
      failures++;
      $display("FAIL rstmid_async: valid=%b busy=%b data=%h, required 0 0 00", char_valid, busy, char_data);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    quiet = 1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (char_valid !== 1'b0 || busy !== 1'b0) quiet = 0;
    end
    checks++;
    if (!quiet) begin
      failures++; $display("FAIL rstmid_quiet: bytes offered after reset without start, required none");
    end
    bm = rand_bitmap();
    build_expected(bm);
    launch(bm);
    capture(0, 0, FRAME + 20, 1'b0, '0);
    d = first_diff();
    checks++;
    if (timed_out != 0 || d >= 0 || got_q[0] !== 8'h1B) begin
      failures++; $display("FAIL rstmid_restart: timeout=%0d first difference %0d, required 0 -1", timed_out, d);
    end
    $display("reset_mid: restarted frame %0d bytes", got_q.size());
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] bm1, bm2;
    int d;
    bm1 = rand_bitmap();
    bm2 = rand_bitmap();
    build_expected(bm1);
    launch(bm1);
    capture(0, 0, FRAME + 20, 1'b1, bm2);
    d = first_diff();
    checks++;
    if (timed_out != 0 || d >= 0) begin
      failures++; $display("FAIL b2b_first: timeout=%0d first difference %0d, required 0 -1", timed_out, d);
    end
    build_expected(bm2);
    capture(1, 0, 3 * FRAME + 20, 1'b0, '0);
    d = first_diff();
    checks++;
    if (timed_out != 0 || d >= 0 || valid_drop != 0) begin
      failures++;
      $display("FAIL b2b_second: timeout=%0d first difference %0d valid drops %0d, required 0 -1 0",
               timed_out, d, valid_drop);
    end
    checks++;
    if (stall_bad != 0 || done_ok != 1) begin
      failures++; $display("FAIL b2b_handshake: stall changes %0d done_ok %0d, required 0 1", stall_bad, done_ok);
    end
    $display("back_to_back: second frame %0d bytes", got_q.size());
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; char_ready = 1'b0; display = '0;
    #1;
    test_reset();
    test_frame("zero", '0, 0);
    test_sparse();
    test_frame("random", rand_bitmap(), 0);
    test_frame("backpressure", '0, 1);
    test_frame("backpressure_rand", rand_bitmap(), 1);
    test_snapshot();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
